// File: rtl/combo_lock_param.sv
// Reprogrammable combination lock: strobed digits are checked on the fly, a correct
// sequence opens a timed window, and repeated failures trigger a timed lockout.
module combo_lock_param #(
    parameter int DIGIT_W     = 4,
    parameter int SEQ_LEN     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int OPEN_CYC    = 256,
    parameter int LOCKOUT_CYC = 1024,
    parameter logic [SEQ_LEN*DIGIT_W-1:0] RESET_CODE = 16'h1234
) (
    input  logic                             CLK,
    input  logic                             masterRST_n,
    input  logic                             RST,
    input  logic [DIGIT_W-1:0]               code,
    input  logic                             code_vld,
    input  logic                             prog,
    output logic                             unlocked,
    output logic                             err,
    output logic                             locked_out,
    output logic                             prog_mode,
    output logic [$clog2(SEQ_LEN+1)-1:0]     digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

    localparam int CODE_W = SEQ_LEN * DIGIT_W;
    localparam int CW     = $clog2(SEQ_LEN + 1);
    localparam int FW     = $clog2(MAX_TRIES + 1);
    localparam int TMAX   = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_LOCKOUT = 3'd3;
    localparam logic [2:0] ST_PROG    = 3'd4;

    localparam logic [CW-1:0] LAST_IDX  = CW'(SEQ_LEN - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_TRIES);
    localparam logic [TW-1:0] T_OPEN    = TW'(OPEN_CYC);
    localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYC);

    // Digit 0 lives in the most significant bits of the packed code.
    function automatic logic [DIGIT_W-1:0] get_digit(input logic [CODE_W-1:0] c,
                                                     input logic [CW-1:0]     idx);
        logic [DIGIT_W-1:0] d;
        d = {DIGIT_W{1'b0}};
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx == CW'(i)) begin
                d = c[(SEQ_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
        return d;
    endfunction

    function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0]  c,
                                                    input logic [CW-1:0]      idx,
                                                    input logic [DIGIT_W-1:0] d);
        logic [CODE_W-1:0] r;
        r = c;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx == CW'(i)) begin
                r[(SEQ_LEN-1-i)*DIGIT_W +: DIGIT_W] = d;
            end
        end
        return r;
    endfunction

    logic [2:0]        r_state;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] r_shadow;
    logic [CW-1:0]     r_digit_cnt;
    logic [FW-1:0]     r_fail_cnt;
    logic              r_match;
    logic [TW-1:0]     r_timer;
    logic              r_err;
    logic              r_unlocked;
    logic              r_locked_out;
    logic              r_prog_mode;

    logic [2:0]        w_state_nxt;
    logic [CODE_W-1:0] w_code_nxt;
    logic [CODE_W-1:0] w_shadow_nxt;
    logic [CODE_W-1:0] w_shadow_wr;
    logic [CW-1:0]     w_cnt_nxt;
    logic [FW-1:0]     w_fail_nxt;
    logic [FW-1:0]     w_fail_inc;
    logic              w_match_nxt;
    logic              w_match_acc;
    logic              w_last;
    logic [TW-1:0]     w_timer_nxt;
    logic              w_err_nxt;

    // Next-state and datapath decisions for the lock FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_shadow_nxt = r_shadow;
        w_cnt_nxt    = r_digit_cnt;
        w_fail_nxt   = r_fail_cnt;
        w_match_nxt  = r_match;
        w_timer_nxt  = r_timer;
        w_err_nxt    = 1'b0;

        w_last      = (r_digit_cnt == LAST_IDX);
        // The running flag is only meaningful once the first digit of an entry is in.
        w_match_acc = ((r_digit_cnt == {CW{1'b0}}) ? 1'b1 : r_match) &
                      (code == get_digit(r_code, r_digit_cnt));
        w_fail_inc  = (r_fail_cnt == FAIL_MAX) ? r_fail_cnt : r_fail_cnt + FW'(1);
        w_shadow_wr = put_digit(r_shadow, r_digit_cnt, code);

        case (r_state)
            ST_IDLE, ST_ENTRY: begin
                if (RST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                    w_match_nxt = 1'b0;
                end else if (code_vld) begin
                    if (w_last) begin
                        w_cnt_nxt   = {CW{1'b0}};
                        w_match_nxt = 1'b0;
                        if (w_match_acc) begin
                            w_state_nxt = ST_OPEN;
                            w_timer_nxt = T_OPEN;
                            w_fail_nxt  = {FW{1'b0}};
                        end else begin
                            w_err_nxt  = 1'b1;
                            w_fail_nxt = w_fail_inc;
                            if (w_fail_inc == FAIL_MAX) begin
                                w_state_nxt = ST_LOCKOUT;
                                w_timer_nxt = T_LOCKOUT;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end else begin
                        w_cnt_nxt   = r_digit_cnt + CW'(1);
                        w_match_nxt = w_match_acc;
                        w_state_nxt = ST_ENTRY;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_OPEN: begin
                if (RST) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = {TW{1'b0}};
                end else if (prog) begin
                    w_state_nxt = ST_PROG;
                    w_cnt_nxt   = {CW{1'b0}};
                    w_timer_nxt = {TW{1'b0}};
                end else if (r_timer <= TW'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = {TW{1'b0}};
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            ST_PROG: begin
                if (RST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else if (code_vld) begin
                    w_shadow_nxt = w_shadow_wr;
                    if (w_last) begin
                        w_code_nxt  = w_shadow_wr;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = {CW{1'b0}};
                    end else begin
                        w_cnt_nxt = r_digit_cnt + CW'(1);
                    end
                end else begin
                    w_state_nxt = ST_PROG;
                end
            end
            ST_LOCKOUT: begin
                if (r_timer <= TW'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = {TW{1'b0}};
                    w_fail_nxt  = {FW{1'b0}};
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
                w_match_nxt = 1'b0;
                w_timer_nxt = {TW{1'b0}};
            end
        endcase
    end

    // State, stored code and registered status outputs.
    always_ff @(posedge CLK or negedge masterRST_n) begin
        if (!masterRST_n) begin
            r_state      <= ST_IDLE;
            r_code       <= RESET_CODE;
            r_shadow     <= {CODE_W{1'b0}};
            r_digit_cnt  <= {CW{1'b0}};
            r_fail_cnt   <= {FW{1'b0}};
            r_match      <= 1'b0;
            r_timer      <= {TW{1'b0}};
            r_err        <= 1'b0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
            r_prog_mode  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_code       <= w_code_nxt;
            r_shadow     <= w_shadow_nxt;
            r_digit_cnt  <= w_cnt_nxt;
            r_fail_cnt   <= w_fail_nxt;
            r_match      <= w_match_nxt;
            r_timer      <= w_timer_nxt;
            r_err        <= w_err_nxt;
            r_unlocked   <= (w_state_nxt == ST_OPEN);
            r_locked_out <= (w_state_nxt == ST_LOCKOUT);
            r_prog_mode  <= (w_state_nxt == ST_PROG);
        end
    end

    assign unlocked   = r_unlocked;
    assign err        = r_err;
    assign locked_out = r_locked_out;
    assign prog_mode  = r_prog_mode;
    assign digit_cnt  = r_digit_cnt;
    assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed bench for combo_lock_param: expected output words are queued as each
// stimulus is driven and popped for comparison once the DUT has registered it.
module tb_combo_lock_param;

    logic       CLK = 1'b0;
    logic       masterRST_n;
    logic       RST;
    logic [3:0] code;
    logic       code_vld;
    logic       prog;
    logic       unlocked;
    logic       err;
    logic       locked_out;
    logic       prog_mode;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    typedef struct {
        logic [8:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    combo_lock_param dut (
        .CLK         (CLK),
        .masterRST_n (masterRST_n),
        .RST         (RST),
        .code        (code),
        .code_vld    (code_vld),
        .prog        (prog),
        .unlocked    (unlocked),
        .err         (err),
        .locked_out  (locked_out),
        .prog_mode   (prog_mode),
        .digit_cnt   (digit_cnt),
        .fail_cnt    (fail_cnt)
    );

    always #5 CLK = ~CLK;

    // Output word: {unlocked, err, locked_out, prog_mode, digit_cnt, fail_cnt}
    function automatic logic [8:0] pk(input logic u, input logic e, input logic l,
                                      input logic p, input logic [2:0] dc,
                                      input logic [1:0] fc);
        return {u, e, l, p, dc, fc};
    endfunction

    task automatic push_exp(input logic [8:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [8:0] obs;
        e   = sb.pop_front();
        obs = {unlocked, err, locked_out, prog_mode, digit_cnt, fail_cnt};
        vectors++;
        assert (obs === e.v) else begin
            miscompares++;
            $error("FAIL %s: observed %b required %b", e.tag, obs, e.v);
        end
    endtask

    task automatic apply(input logic vld, input logic [3:0] d, input logic p,
                         input logic r, input logic [8:0] exp_v, input string tag);
        code_vld = vld;
        code     = d;
        prog     = p;
        RST      = r;
        push_exp(exp_v, tag);
        @(posedge CLK);
        #1;
        code_vld = 1'b0;
        prog     = 1'b0;
        RST      = 1'b0;
        pop_check();
    endtask

    task automatic idle_n(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic attempt(input logic [15:0] c, input logic [1:0] fc_before,
                           input logic [8:0] final_v, input string tag);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, c[15-4*i -: 4], 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 3'(i+1), fc_before),
                  {tag, "_digit"});
        end
        apply(1'b1, c[3:0], 1'b0, 1'b0, final_v, tag);
    endtask

    task automatic relock(input string tag);
        apply(1'b0, 4'h0, 1'b0, 1'b1, pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0), tag);
    endtask

    initial begin
        logic [8:0] open_v;
        logic [15:0] lock_seq;
        open_v      = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        lock_seq    = 16'h1234;
        masterRST_n = 1'b0;
        RST         = 1'b0;
        code        = 4'h0;
        code_vld    = 1'b0;
        prog        = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        push_exp(9'd0, "reset_state");
        pop_check();
        @(negedge CLK);
        masterRST_n = 1'b1;

        // Correct code opens for exactly OPEN_CYC cycles
        attempt(16'h1234, 2'd0, open_v, "t1_open");
        idle_n(254);
        apply(1'b0, 4'h0, 1'b0, 1'b0, open_v, "t1_open_last_cycle");
        apply(1'b0, 4'h0, 1'b0, 1'b0, 9'd0, "t1_open_expired");

        // Three wrong sequences, then lockout that ignores digits
        for (int k = 1; k <= 3; k++) begin
            attempt(16'h1235, 2'(k-1), pk(1'b0, 1'b1, 1'(k == 3), 1'b0, 3'd0, 2'(k)), "t2_wrong");
            apply(1'b0, 4'h0, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'(k == 3), 1'b0, 3'd0, 2'(k)),
                  "t2_err_pulse_end");
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, lock_seq[15-4*i -: 4], 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd3),
                  "t2_lockout_ignores");
        end
        idle_n(1017);
        apply(1'b0, 4'h0, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd3), "t2_lockout_last");
        apply(1'b0, 4'h0, 1'b0, 1'b0, 9'd0, "t2_lockout_end");
        attempt(16'h1234, 2'd0, open_v, "t2_open_after");
        relock("t2_rst_relock");

        // Programming aborted by RST keeps the old code
        attempt(16'h1234, 2'd0, open_v, "t4_open");
        apply(1'b0, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0), "t4_prog_enter");
        apply(1'b1, 4'h9, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 2'd0), "t4_prog_d1");
        apply(1'b1, 4'h8, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 2'd0), "t4_prog_d2");
        apply(1'b0, 4'h0, 1'b0, 1'b1, 9'd0, "t4_prog_abort");
        attempt(16'h1234, 2'd0, open_v, "t4_old_code");
        relock("t4_rst_relock");

        // RST with a simultaneous digit discards the digit, keeps fail_cnt
        attempt(16'h1235, 2'd0, pk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1), "t5_wrong");
        apply(1'b0, 4'h0, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1), "t5_err_end");
        apply(1'b1, 4'h1, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd1), "t5_d1");
        apply(1'b1, 4'h2, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd1), "t5_d2");
        apply(1'b1, 4'h3, 1'b0, 1'b1, pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1), "t5_rst_with_vld");
        attempt(16'h1234, 2'd1, open_v, "t5_open");
        relock("t5_rst_relock");

        // Program 9876
        attempt(16'h1234, 2'd0, open_v, "t3_open");
        apply(1'b0, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0), "t3_prog_enter");
        apply(1'b1, 4'h9, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 2'd0), "t3_prog_d1");
        apply(1'b1, 4'h8, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 2'd0), "t3_prog_d2");
        apply(1'b1, 4'h7, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 2'd0), "t3_prog_d3");
        apply(1'b1, 4'h6, 1'b0, 1'b0, 9'd0, "t3_prog_done");
        attempt(16'h1234, 2'd0, pk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1), "t3_old_rejected");
        apply(1'b0, 4'h0, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1), "t3_err_end");
        attempt(16'h9876, 2'd1, open_v, "t3_new_opens");
        relock("t3_rst_relock");

        // prog on the timer-expiry cycle wins over returning to IDLE
        attempt(16'h9876, 2'd0, open_v, "t7_open");
        idle_n(255);
        apply(1'b0, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0), "t7_prog_at_expiry");
        apply(1'b0, 4'h0, 1'b0, 1'b1, 9'd0, "t7_prog_abort");

        // Asynchronous master reset mid-entry restores the reset code
        apply(1'b1, 4'h9, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0), "t6_d1");
        apply(1'b1, 4'h8, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0), "t6_d2");
        #2;
        masterRST_n = 1'b0;
        #1;
        push_exp(9'd0, "t6_async_reset");
        pop_check();
        @(negedge CLK);
        masterRST_n = 1'b1;
        attempt(16'h1234, 2'd0, open_v, "t6_reset_code_opens");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
